// File: rtl/cnn_pkg.sv
// Shared CNN types and sizes: sequencer state encoding, default layer count,
// counter widths and a layer one-hot helper.
package cnn_pkg;

  localparam int unsigned NUM_LAYERS_DEF = 4;
  localparam int unsigned MAX_LAYERS     = 8;
  localparam int unsigned LAYER_IDX_W    = 3;
  localparam int unsigned CLR_CNT_W      = 3;
  localparam int unsigned TIMER_W        = 32;
  localparam int unsigned TOTAL_W        = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } seq_state_e;

  function automatic logic [MAX_LAYERS-1:0] layer_onehot(input logic [LAYER_IDX_W-1:0] idx);
    return MAX_LAYERS'(1) << idx;
  endfunction

endpackage

// File: rtl/cnn_seq_timer.sv
// Per-layer run counter: held clear outside RUN, counts RUN cycles and raises
// a registered flag during the TIMEOUT_CYCLES-th RUN cycle.
module cnn_seq_timer
  import cnn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic timeout_o
);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;
  logic               timeout_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TIMER_W'(1);
    end
  end

  // Flag is looked ahead one cycle so it is high in the cycle the budget is used up.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= (cnt_d == TIMER_W'(TIMEOUT_CYCLES - 1));
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Sequences a chain of CNN layer engines: per-layer clear, run until done or
// timeout, ping-pong bank select, and a busy-cycle counter for the whole chain.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_LAYERS     = NUM_LAYERS_DEF,
  parameter int unsigned CLEAR_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_rst,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic                  bank_sel,
  output logic [2:0]            cur_layer,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           total_cycles
);

  seq_state_e             state_q;
  seq_state_e             state_d;
  logic [LAYER_IDX_W-1:0] cur_q;
  logic [LAYER_IDX_W-1:0] cur_d;
  logic                   bank_q;
  logic                   bank_d;
  logic [CLR_CNT_W-1:0]   clr_cnt_q;
  logic [CLR_CNT_W-1:0]   clr_cnt_d;
  logic [TOTAL_W-1:0]     total_q;
  logic [TOTAL_W-1:0]     total_d;

  logic [NUM_LAYERS-1:0]  layer_rst_q;
  logic [NUM_LAYERS-1:0]  layer_rst_d;
  logic [NUM_LAYERS-1:0]  layer_start_q;
  logic [NUM_LAYERS-1:0]  layer_start_d;
  logic                   busy_q;
  logic                   busy_d;
  logic                   done_q;
  logic                   done_d;
  logic                   error_q;
  logic                   error_d;

  logic                   busy_st;
  logic                   cur_done;
  logic                   timeout;

  assign busy_st  = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_NEXT);
  // Only the active layer's done bit matters; stale bits of other layers are masked.
  assign cur_done = |(MAX_LAYERS'(layer_done) & layer_onehot(cur_q));

  cnn_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != S_RUN),
    .en_i     (state_q == S_RUN),
    .timeout_o(timeout)
  );

  // State and datapath registers, plus the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      bank_q        <= 1'b0;
      clr_cnt_q     <= '0;
      total_q       <= '0;
      layer_rst_q   <= '1;
      layer_start_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      bank_q        <= bank_d;
      clr_cnt_q     <= clr_cnt_d;
      total_q       <= total_d;
      layer_rst_q   <= layer_rst_d;
      layer_start_q <= layer_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  // Next state; done beats timeout in RUN, start is only heard when not busy.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    bank_d    = bank_q;
    clr_cnt_d = '0;
    total_d   = total_q;
    if (busy_st && (total_q != '1)) begin
      total_d = total_q + TOTAL_W'(1);
    end
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_CLEAR;
          cur_d   = '0;
          bank_d  = 1'b0;
          total_d = '0;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == CLR_CNT_W'(CLEAR_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_CNT_W'(1);
        end
      end
      S_RUN: begin
        if (cur_done) begin
          state_d = S_NEXT;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_NEXT: begin
        if (cur_q == LAYER_IDX_W'(NUM_LAYERS - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CLEAR;
          cur_d   = cur_q + LAYER_IDX_W'(1);
          bank_d  = ~bank_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the upcoming state, loaded into the output registers.
  always_comb begin
    layer_rst_d   = '0;
    layer_start_d = '0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    error_d       = 1'b0;
    case (state_d)
      S_CLEAR: begin
        layer_rst_d = NUM_LAYERS'(layer_onehot(cur_d));
        busy_d      = 1'b1;
      end
      S_RUN: begin
        layer_start_d = NUM_LAYERS'(layer_onehot(cur_d));
        busy_d        = 1'b1;
      end
      S_NEXT:  busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      S_ERROR: begin
        layer_rst_d = '1;
        error_d     = 1'b1;
      end
      default: ;
    endcase
  end

  assign layer_rst    = layer_rst_q;
  assign layer_start  = layer_start_q;
  assign bank_sel     = bank_q;
  assign cur_layer    = cur_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign total_cycles = total_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: directed scenario table plus randomized chains,
// each checked cycle by cycle against an expected timeline built from layer run lengths.
module tb_cnn_layer_sequencer;

  localparam int NL  = 3;
  localparam int CLR = 2;
  localparam int TMO = 50;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] cur;
    logic       bank;
    logic [2:0] lrst;
    logic [2:0] lstart;
  } obs_t;

  typedef struct {
    int         r0;
    int         r1;
    int         r2;
    logic [2:0] stale;
    bit         mid_start;
    logic       exp_done;
    logic       exp_err;
    int         exp_total;
    int         exp_cur;
    logic       exp_bank;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NL-1:0] layer_done;
  logic [NL-1:0] layer_rst;
  logic [NL-1:0] layer_start;
  logic          bank_sel;
  logic [2:0]    cur_layer;
  logic          busy;
  logic          done;
  logic          error;
  logic [31:0]   total_cycles;

  int n_cmp  = 0;
  int n_fail = 0;
  int stub_tgt[NL];
  int stub_cnt[NL];

  cnn_layer_sequencer #(
    .NUM_LAYERS    (NL),
    .CLEAR_CYCLES  (CLR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .layer_done  (layer_done),
    .layer_rst   (layer_rst),
    .layer_start (layer_start),
    .bank_sel    (bank_sel),
    .cur_layer   (cur_layer),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .total_cycles(total_cycles)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic b, input logic d, input logic e, input logic [2:0] c,
                              input logic bk, input logic [2:0] lr, input logic [2:0] ls);
    obs_t o;
    o.busy = b; o.done = d; o.err = e; o.cur = c; o.bank = bk; o.lrst = lr; o.lstart = ls;
    return o;
  endfunction

  function automatic obs_t cur_obs();
    return mk(busy, done, error, cur_layer, bank_sel, layer_rst, layer_start);
  endfunction

  // Engine stubs: sticky done once the start has been seen for tgt cycles; cleared by layer_rst.
  task automatic stub_update();
    for (int i = 0; i < NL; i++) begin
      if (layer_rst[i]) begin
        stub_cnt[i]   = 0;
        layer_done[i] = 1'b0;
      end else if (layer_start[i]) begin
        stub_cnt[i]++;
        if (stub_tgt[i] != 0 && stub_cnt[i] >= stub_tgt[i]) layer_done[i] = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    stub_update();
  endtask

  task automatic check_obs(input string nm, input obs_t exp);
    obs_t got;
    got = cur_obs();
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy/done/err=%b%b%b cur=%0d bank=%b rst=%b start=%b, expected busy/done/err=%b%b%b cur=%0d bank=%b rst=%b start=%b",
               nm, got.busy, got.done, got.err, got.cur, got.bank, got.lrst, got.lstart,
               exp.busy, exp.done, exp.err, exp.cur, exp.bank, exp.lrst, exp.lstart);
    end
  endtask

  task automatic check_val(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Expected cycle-by-cycle view of one chain: per layer CLR clear cycles, R run cycles, one
  // hand-over cycle; a layer whose R is 0 or beyond the timeout runs TMO cycles and then errors.
  task automatic build_timeline(input int rr[NL], output obs_t tl[$], output int nbusy);
    tl = {};
    nbusy = 0;
    for (int i = 0; i < NL; i++) begin
      logic       bk;
      logic [2:0] sel;
      bit         to;
      int         rlen;
      bk   = 1'(i % 2);
      sel  = 3'(1 << i);
      to   = (rr[i] == 0) || (rr[i] > TMO);
      rlen = to ? TMO : rr[i];
      for (int c = 0; c < CLR; c++) tl.push_back(mk(1'b1, 1'b0, 1'b0, 3'(i), bk, sel, 3'b000));
      for (int c = 0; c < rlen; c++) tl.push_back(mk(1'b1, 1'b0, 1'b0, 3'(i), bk, 3'b000, sel));
      if (to) begin
        nbusy = tl.size();
        tl.push_back(mk(1'b0, 1'b0, 1'b1, 3'(i), bk, 3'b111, 3'b000));
        return;
      end
      tl.push_back(mk(1'b1, 1'b0, 1'b0, 3'(i), bk, 3'b000, 3'b000));
    end
    nbusy = tl.size();
    tl.push_back(mk(1'b0, 1'b1, 1'b0, 3'(NL - 1), 1'(((NL - 1) % 2)), 3'b000, 3'b000));
  endtask

  task automatic run_chain(input int r0, input int r1, input int r2, input logic [2:0] stale,
                           input bit mid_start, input string tag);
    obs_t tl[$];
    int   nbusy;
    int   rr[NL];
    obs_t term;
    rr[0] = r0; rr[1] = r1; rr[2] = r2;
    build_timeline(rr, tl, nbusy);
    for (int i = 0; i < NL; i++) stub_tgt[i] = rr[i];
    layer_done = layer_done | stale;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < tl.size(); k++) begin
      check_obs($sformatf("%s_cyc%0d", tag, k), tl[k]);
      if (k == tl.size() - 1) break;
      if (mid_start && k == CLR + 2) start = 1'b1;
      step();
      start = 1'b0;
    end
    check_val({tag, "_total"}, longint'(total_cycles), longint'(nbusy));
    term = tl[tl.size() - 1];
    for (int h = 0; h < 3; h++) begin
      step();
      check_obs($sformatf("%s_hold%0d", tag, h), term);
    end
    check_val({tag, "_total_frozen"}, longint'(total_cycles), longint'(nbusy));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{r0:10, r1:20, r2:30, stale:3'b000, mid_start:0, exp_done:1, exp_err:0, exp_total:69,  exp_cur:2, exp_bank:0};
    vecs[1] = '{r0:10, r1:0,  r2:30, stale:3'b000, mid_start:0, exp_done:0, exp_err:1, exp_total:65,  exp_cur:1, exp_bank:1};
    vecs[2] = '{r0:10, r1:20, r2:30, stale:3'b000, mid_start:1, exp_done:1, exp_err:0, exp_total:69,  exp_cur:2, exp_bank:0};
    vecs[3] = '{r0:50, r1:5,  r2:7,  stale:3'b000, mid_start:0, exp_done:1, exp_err:0, exp_total:71,  exp_cur:2, exp_bank:0};
    vecs[4] = '{r0:4,  r1:6,  r2:8,  stale:3'b100, mid_start:0, exp_done:1, exp_err:0, exp_total:27,  exp_cur:2, exp_bank:0};
    vecs[5] = '{r0:2,  r1:2,  r2:2,  stale:3'b000, mid_start:0, exp_done:1, exp_err:0, exp_total:15,  exp_cur:2, exp_bank:0};
    vecs[6] = '{r0:0,  r1:5,  r2:5,  stale:3'b000, mid_start:0, exp_done:0, exp_err:1, exp_total:52,  exp_cur:0, exp_bank:0};
    vecs[7] = '{r0:49, r1:50, r2:3,  stale:3'b110, mid_start:1, exp_done:1, exp_err:0, exp_total:111, exp_cur:2, exp_bank:0};
    vecs[8] = '{r0:3,  r1:4,  r2:0,  stale:3'b000, mid_start:0, exp_done:0, exp_err:1, exp_total:65,  exp_cur:2, exp_bank:0};

    rst        = 1'b1;
    start      = 1'b0;
    layer_done = '0;
    for (int i = 0; i < NL; i++) begin
      stub_tgt[i] = 0;
      stub_cnt[i] = 0;
    end
    step();
    step();
    check_obs("reset", mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'b111, 3'b000));
    check_val("reset_total", longint'(total_cycles), 0);
    rst = 1'b0;
    step();
    check_obs("idle", mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'b000, 3'b000));

    for (int v = 0; v < 9; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_chain(vecs[v].r0, vecs[v].r1, vecs[v].r2, vecs[v].stale, vecs[v].mid_start, tag);
      check_val({tag, "_done"},  longint'(done),         longint'(vecs[v].exp_done));
      check_val({tag, "_error"}, longint'(error),        longint'(vecs[v].exp_err));
      check_val({tag, "_cur"},   longint'(cur_layer),    longint'(vecs[v].exp_cur));
      check_val({tag, "_bank"},  longint'(bank_sel),     longint'(vecs[v].exp_bank));
      check_val({tag, "_tot"},   longint'(total_cycles), longint'(vecs[v].exp_total));
    end

    // Abort in the middle of the last layer's run, then a clean restart from layer 0.
    stub_tgt[0] = 5; stub_tgt[1] = 5; stub_tgt[2] = 40;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    check_obs("pre_rst", mk(1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 3'b000, 3'b100));
    rst = 1'b1;
    step();
    check_obs("rst_mid", mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'b111, 3'b000));
    check_val("rst_mid_total", longint'(total_cycles), 0);
    rst = 1'b0;
    step();
    check_obs("post_rst_idle", mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'b000, 3'b000));
    repeat (5) step();
    check_obs("no_restart", mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'b000, 3'b000));
    run_chain(8, 9, 10, 3'b000, 1'b0, "after_rst");
    check_val("after_rst_tot", longint'(total_cycles), 36);

    for (int t = 0; t < 25; t++) begin
      int         a;
      int         b;
      int         c;
      logic [2:0] st;
      bit         ms;
      a  = int'($urandom_range(2, 56));
      b  = int'($urandom_range(2, 56));
      c  = int'($urandom_range(2, 56));
      st = 3'($urandom_range(0, 7));
      ms = (a >= 3) && ($urandom_range(0, 2) == 0);
      run_chain(a, b, c, st, ms, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
